// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package reg_writeback_arbiter_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // Origin of the value currently held in the output register.
    typedef enum logic {
        SrcPipe = 1'b0,
        SrcFifo = 1'b1
    } wb_src_e;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Pipeline/MDU/decode/register-file signals of the writeback arbiter.
// slave = arbiter side, master = surrounding core.
interface reg_writeback_arbiter_if;
    import reg_writeback_arbiter_pkg::*;

    logic                  PIPE_WE;
    logic [REG_ADDR_W-1:0] PIPE_ADDR;
    logic [XLEN-1:0]       PIPE_DATA;
    logic                  MDU_VALID;
    logic                  MDU_READY;
    logic [REG_ADDR_W-1:0] MDU_ADDR;
    logic [XLEN-1:0]       MDU_DATA;
    logic                  ISSUE_VALID;
    logic [REG_ADDR_W-1:0] ISSUE_RD;
    logic [REG_ADDR_W-1:0] DEC_RS1;
    logic [REG_ADDR_W-1:0] DEC_RS2;
    logic [REG_ADDR_W-1:0] DEC_RD;
    logic                  HAZARD;
    logic                  PIPE_HOLD;
    logic [REG_ADDR_W-1:0] WB_ADDRESS;
    logic                  WRITE_ENABLE;
    logic [XLEN-1:0]       WRITE_DATA;

    modport slave (
        input  PIPE_WE, PIPE_ADDR, PIPE_DATA, MDU_VALID, MDU_ADDR, MDU_DATA,
               ISSUE_VALID, ISSUE_RD, DEC_RS1, DEC_RS2, DEC_RD,
        output MDU_READY, HAZARD, PIPE_HOLD, WB_ADDRESS, WRITE_ENABLE, WRITE_DATA
    );

    modport master (
        output PIPE_WE, PIPE_ADDR, PIPE_DATA, MDU_VALID, MDU_ADDR, MDU_DATA,
               ISSUE_VALID, ISSUE_RD, DEC_RS1, DEC_RS2, DEC_RD,
        input  MDU_READY, HAZARD, PIPE_HOLD, WB_ADDRESS, WRITE_ENABLE, WRITE_DATA
    );

endinterface

// File: rtl/reg_writeback_arbiter_fifo.sv
// wb_result_fifo: synchronous FIFO buffering MDU results, asynchronous active-high reset.
// Depth must be a power of two so the pointers wrap naturally.
module wb_result_fifo
    import reg_writeback_arbiter_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            push,
    input  wb_entry_t       push_data,
    input  logic            pop,
    output wb_entry_t       pop_data,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    wb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

    // Storage needs no reset: the cleared count makes stale entries unreachable.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Register-file write port arbiter: pipeline WB wins over buffered MDU results; busy scoreboard
// drives the decode hazard. Optional starvation guard via `define WB_STARVE_GUARD_EN.
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                     CLK,
    input logic                     RESET,
    reg_writeback_arbiter_if.slave  bus
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t             mdu_entry;
    wb_entry_t             head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CntW-1:0]       fifo_count;

    logic                  we_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       data_q;
    wb_src_e               src_q;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    assign mdu_entry = '{addr: bus.MDU_ADDR, data: bus.MDU_DATA};
    assign bus.MDU_READY = (fifo_count != CntW'(FIFO_DEPTH));
    assign fifo_push = bus.MDU_VALID && bus.MDU_READY;
    assign fifo_pop  = !bus.PIPE_WE && !fifo_empty;

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (fifo_push),
        .push_data (mdu_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Set wins over a same-edge clear; x0 never becomes busy.
    always_comb begin
        busy_d = busy_q;
        if (we_q && (src_q == SrcFifo)) busy_d[addr_q] = 1'b0;
        if (bus.ISSUE_VALID && (bus.ISSUE_RD != '0)) busy_d[bus.ISSUE_RD] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            src_q  <= SrcPipe;
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
            if (bus.PIPE_WE) begin
                we_q   <= (bus.PIPE_ADDR != '0);
                addr_q <= bus.PIPE_ADDR;
                data_q <= bus.PIPE_DATA;
                src_q  <= SrcPipe;
            end else if (fifo_pop) begin
                we_q   <= (head.addr != '0);
                addr_q <= head.addr;
                data_q <= head.data;
                src_q  <= SrcFifo;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    assign bus.WRITE_ENABLE = we_q;
    assign bus.WB_ADDRESS   = addr_q;
    assign bus.WRITE_DATA   = data_q;
    assign bus.HAZARD       = busy_q[bus.DEC_RS1] | busy_q[bus.DEC_RS2] | busy_q[bus.DEC_RD];

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_q;
    logic [StarveW-1:0] starve_d;
    logic               hold_q;

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop) begin
            starve_d = '0;
        end else if (!fifo_empty && bus.PIPE_WE && (starve_q != StarveW'(STARVE_LIMIT))) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            hold_q   <= (starve_d == StarveW'(STARVE_LIMIT));
        end
    end

    assign bus.PIPE_HOLD = hold_q;
`else
    assign bus.PIPE_HOLD = 1'b0;
`endif

    // Sink for values that are only informative in some configurations.
    logic unused_ok;
    assign unused_ok = ^{fifo_full, STARVE_LIMIT};

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed self-checking bench for reg_writeback_arbiter.
module tb_reg_writeback_arbiter;
    import reg_writeback_arbiter_pkg::*;

    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_bad;

    reg_writeback_arbiter_if bus();

    reg_writeback_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check_eq({tag, "_we"}, 32'(bus.WRITE_ENABLE), 32'(we));
        check_eq({tag, "_addr"}, 32'(bus.WB_ADDRESS), 32'(addr));
        check_eq({tag, "_data"}, bus.WRITE_DATA, data);
    endtask

    logic [4:0]  e_addr [5];
    logic [31:0] e_data [5];
    logic        exp_hold;

    initial begin
        n_checks = 0;
        n_bad    = 0;
        bus.PIPE_WE = 0; bus.PIPE_ADDR = 0; bus.PIPE_DATA = 0;
        bus.MDU_VALID = 0; bus.MDU_ADDR = 0; bus.MDU_DATA = 0;
        bus.ISSUE_VALID = 0; bus.ISSUE_RD = 0;
        bus.DEC_RS1 = 0; bus.DEC_RS2 = 0; bus.DEC_RD = 0;

        // Reset asserted from time 0, released mid-cycle at 20ns.
        RESET = 1'b1;
        #2;
        check_wb("rst", 1'b0, 5'd0, 32'h0);
        check_eq("rst_ready", 32'(bus.MDU_READY), 32'd1);
        check_eq("rst_hazard", 32'(bus.HAZARD), 32'd0);
        check_eq("rst_hold", 32'(bus.PIPE_HOLD), 32'd0);
        #18;
        RESET = 1'b0;
        step();

        // Pipeline writes, x0 suppression, hold of address/data when idle.
        bus.PIPE_WE = 1; bus.PIPE_ADDR = 5'd15; bus.PIPE_DATA = 32'hAAAA_AAAA;
        step();
        check_wb("pipe15", 1'b1, 5'd15, 32'hAAAA_AAAA);
        bus.PIPE_ADDR = 5'd0; bus.PIPE_DATA = 32'hFFFF_FFFF;
        step();
        check_eq("pipe_x0_we", 32'(bus.WRITE_ENABLE), 32'd0);
        bus.PIPE_WE = 0;
        step();
        check_wb("idle_hold", 1'b0, 5'd0, 32'hFFFF_FFFF);

        // Scoreboard: issue x20, MDU result pushed in cycle N.
        bus.ISSUE_VALID = 1; bus.ISSUE_RD = 5'd20;
        step();
        bus.ISSUE_VALID = 0; bus.DEC_RS1 = 5'd20;
        #1;
        check_eq("haz_rs1", 32'(bus.HAZARD), 32'd1);
        bus.DEC_RS1 = 5'd19;
        #1;
        check_eq("haz_other", 32'(bus.HAZARD), 32'd0);
        bus.MDU_VALID = 1; bus.MDU_ADDR = 5'd20; bus.MDU_DATA = 32'h1234_5678;
        step();
        bus.MDU_VALID = 0;
        check_eq("mdu_n1_we", 32'(bus.WRITE_ENABLE), 32'd0);
        step();
        check_wb("mdu_n2", 1'b1, 5'd20, 32'h1234_5678);
        bus.DEC_RS1 = 5'd0; bus.DEC_RD = 5'd20;
        #1;
        check_eq("haz_rd_n2", 32'(bus.HAZARD), 32'd1);
        step();
        check_eq("haz_rd_n3", 32'(bus.HAZARD), 32'd0);
        check_eq("mdu_n3_we", 32'(bus.WRITE_ENABLE), 32'd0);
        bus.DEC_RD = 5'd0;

        // Contention: MDU x21 while the pipeline writes for 3 cycles.
        bus.PIPE_WE = 1; bus.PIPE_ADDR = 5'd1; bus.PIPE_DATA = 32'h1111_1111;
        bus.ISSUE_VALID = 1; bus.ISSUE_RD = 5'd21;
        bus.MDU_VALID = 1; bus.MDU_ADDR = 5'd21; bus.MDU_DATA = 32'h8765_4321;
        step();
        bus.ISSUE_VALID = 0; bus.MDU_VALID = 0;
        check_wb("cont_p1", 1'b1, 5'd1, 32'h1111_1111);
        bus.PIPE_ADDR = 5'd2; bus.PIPE_DATA = 32'h2222_2222;
        step();
        check_wb("cont_p2", 1'b1, 5'd2, 32'h2222_2222);
        bus.PIPE_ADDR = 5'd3; bus.PIPE_DATA = 32'h3333_3333;
        step();
        check_wb("cont_p3", 1'b1, 5'd3, 32'h3333_3333);
        bus.PIPE_WE = 0; bus.DEC_RS2 = 5'd21;
        #1;
        check_eq("cont_haz", 32'(bus.HAZARD), 32'd1);
        step();
        check_wb("cont_x21", 1'b1, 5'd21, 32'h8765_4321);
        step();
        check_eq("cont_haz_clr", 32'(bus.HAZARD), 32'd0);
        check_eq("cont_idle_we", 32'(bus.WRITE_ENABLE), 32'd0);
        bus.DEC_RS2 = 5'd0;

        // Full FIFO: pipeline blocks pops while 5 results arrive back-to-back.
        for (int i = 0; i < 5; i++) begin
            e_addr[i] = 5'(22 + i);
            e_data[i] = 32'hF000_0000 + 32'(i);
        end
        bus.PIPE_WE = 1; bus.PIPE_ADDR = 5'd0; bus.MDU_VALID = 1;
        for (int i = 0; i < 4; i++) begin
            bus.MDU_ADDR = e_addr[i]; bus.MDU_DATA = e_data[i];
            #1;
            check_eq("fill_ready", 32'(bus.MDU_READY), 32'd1);
            step();
        end
        bus.MDU_ADDR = e_addr[4]; bus.MDU_DATA = e_data[4];
        check_eq("full_ready", 32'(bus.MDU_READY), 32'd0);
        step();
        check_eq("full_ready_held", 32'(bus.MDU_READY), 32'd0);
        bus.PIPE_WE = 0;
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) bus.MDU_VALID = 0;
            check_wb($sformatf("drain%0d", k), 1'b1, e_addr[k], e_data[k]);
            step();
        end
        check_eq("drain_done_we", 32'(bus.WRITE_ENABLE), 32'd0);

        // Reset with two buffered results and busy bits outstanding.
        bus.PIPE_WE = 1; bus.PIPE_ADDR = 5'd3; bus.PIPE_DATA = 32'h0000_0003;
        bus.ISSUE_VALID = 1; bus.ISSUE_RD = 5'd7;
        bus.MDU_VALID = 1; bus.MDU_ADDR = 5'd7; bus.MDU_DATA = 32'h0000_0007;
        step();
        bus.ISSUE_RD = 5'd8; bus.MDU_ADDR = 5'd8; bus.MDU_DATA = 32'h0000_0008;
        step();
        bus.ISSUE_VALID = 0; bus.MDU_VALID = 0; bus.DEC_RS1 = 5'd7; bus.DEC_RS2 = 5'd8;
        #1;
        check_eq("pre_rst_haz", 32'(bus.HAZARD), 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        check_eq("mid_rst_haz", 32'(bus.HAZARD), 32'd0);
        check_eq("mid_rst_we", 32'(bus.WRITE_ENABLE), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.MDU_READY), 32'd1);
        #3;
        RESET = 1'b0;
        bus.PIPE_WE = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("post_rst_we", 32'(bus.WRITE_ENABLE), 32'd0);
            check_eq("post_rst_haz", 32'(bus.HAZARD), 32'd0);
        end
        bus.DEC_RS1 = 5'd0; bus.DEC_RS2 = 5'd0;

        // Starvation: one buffered result blocked by 8 pipeline cycles.
`ifdef WB_STARVE_GUARD_EN
        exp_hold = 1'b1;
`else
        exp_hold = 1'b0;
`endif
        bus.PIPE_WE = 1; bus.PIPE_ADDR = 5'd0;
        bus.MDU_VALID = 1; bus.MDU_ADDR = 5'd0; bus.MDU_DATA = 32'h0;
        step();
        bus.MDU_VALID = 0;
        for (int c = 1; c <= 8; c++) begin
            check_eq($sformatf("starve_c%0d", c), 32'(bus.PIPE_HOLD), 32'd0);
            step();
        end
        check_eq("starve_hold", 32'(bus.PIPE_HOLD), 32'(exp_hold));
        bus.PIPE_WE = 0;
        step();
        check_eq("starve_release", 32'(bus.PIPE_HOLD), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Write-side driver for the 32x32 integer register file. Owns its single write port: WB_ADDRESS, WRITE_ENABLE, WRITE_DATA.
- Merges two result sources:
  - the in-order pipeline WB stage, which cannot stall;
  - the multi-cycle RV32M mul/div unit (MDU), whose results are buffered in a small FIFO.
- Keeps a busy scoreboard of destination registers with outstanding MDU results and raises a decode hazard against them.

Parameters:
- FIFO_DEPTH, 4, MDU result buffer entries; power of 2, minimum 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before a hold request; used only with the optional feature.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- PIPE_WE  input  1  pipeline WB write request.
- PIPE_ADDR  input  5  pipeline destination register.
- PIPE_DATA  input  32  pipeline result.
- MDU_VALID  input  1  MDU result available.
- MDU_READY  output  1  FIFO can accept an MDU result.
- MDU_ADDR  input  5  MDU destination register.
- MDU_DATA  input  32  MDU result.
- ISSUE_VALID  input  1  long-latency op issued this cycle.
- ISSUE_RD  input  5  destination of the issued op.
- DEC_RS1  input  5  decode-stage source 1.
- DEC_RS2  input  5  decode-stage source 2.
- DEC_RD  input  5  decode-stage destination.
- HAZARD  output  1  decode must stall.
- PIPE_HOLD  output  1  request a pipeline WB bubble.
- WB_ADDRESS  output  5  register-file write address.
- WRITE_ENABLE  output  1  register-file write enable.
- WRITE_DATA  output  32  register-file write data.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - WRITE_ENABLE=0, WB_ADDRESS=0, WRITE_DATA=0, PIPE_HOLD=0.
  - FIFO emptied; pointers and count cleared.
  - Scoreboard cleared to all zero, so HAZARD=0 and MDU_READY=1.
  - FIFO contents at reset are discarded; no write is produced for them after reset releases.
- Output register:
  - WB_ADDRESS, WRITE_ENABLE and WRITE_DATA are registered.
  - The register file commits on the edge that ends the cycle in which WRITE_ENABLE=1.
- Source priority each cycle:
  - PIPE_WE=1: load the pipeline write. Latency is 1 cycle from input to WRITE_ENABLE.
  - PIPE_WE=0 and FIFO non-empty: pop the FIFO head and load it.
  - Otherwise WRITE_ENABLE=0. WB_ADDRESS and WRITE_DATA hold their previous values.
- x0 suppression:
  - A loaded write with address 0 drives WRITE_ENABLE=0.
  - An MDU result with address 0 is still accepted and popped normally.
- FIFO:
  - Push when MDU_VALID && MDU_READY.
  - MDU_READY = (count != FIFO_DEPTH). It ignores a same-cycle pop, so there is no full pass-through.
  - No bypass: an entry pushed in cycle N pops in cycle N+1 at the earliest and reaches WRITE_ENABLE in N+2.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Entries drain in strict FIFO order.
- Scoreboard (32-bit busy vector):
  - ISSUE_VALID with ISSUE_RD != 0 sets busy[ISSUE_RD]. ISSUE_RD=0 is ignored.
  - A bit clears on the commit edge of an FIFO-sourced write to that register, i.e. the edge that ends the WRITE_ENABLE=1 cycle. A source-tag flop records FIFO versus pipeline origin of the output register.
  - Set and clear of the same bit on the same edge: set wins.
  - A pipeline-sourced write never clears a busy bit.
- HAZARD:
  - Combinational: HAZARD = busy[DEC_RS1] | busy[DEC_RS2] | busy[DEC_RD].
  - busy[0] is always 0.
  - The DEC_RD term prevents a second outstanding write to the same rd (WAW). Issuing to an rd that is already busy is therefore illegal upstream.
- PIPE_HOLD is constant 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- With the macro:
  - A saturating counter increments every cycle in which the FIFO is non-empty and PIPE_WE=1.
  - It clears on any FIFO pop and on reset.
  - PIPE_HOLD is registered and asserts once the counter reaches STARVE_LIMIT.
  - PIPE_HOLD stays high until the next pop. The pipeline must present PIPE_WE=0 while PIPE_HOLD=1.
- Without the macro:
  - No counter.
  - PIPE_HOLD is tied to 0; an unbroken pipeline write stream may starve the FIFO indefinitely.

Decomposition:
- Shared package:
  - XLEN=32, REG_ADDR_W=5, NUM_REGS=32.
  - Packed wb_entry typedef: {addr[4:0], data[31:0]}.
- Sub-module: wb_result_fifo. It is a parameterised synchronous FIFO with push/pop, full/empty, count and asynchronous RESET.
- Arbitration, the scoreboard and the output register stay in the top module.

Test Plan:
- Reset:
  - Assert RESET for 20ns, releasing mid-cycle → all outputs 0 immediately, MDU_READY=1, HAZARD=0.
- Pipeline writes:
  - PIPE_WE=1, PIPE_ADDR=15, PIPE_DATA=AAAAAAAA → next cycle WRITE_ENABLE=1, WB_ADDRESS=15, WRITE_DATA=AAAAAAAA.
  - PIPE_ADDR=0, PIPE_DATA=FFFFFFFF → WRITE_ENABLE=0.
- Scoreboard:
  - Issue rd=20, then DEC_RS1=20 → HAZARD=1.
  - MDU pushes x20=12345678 in cycle N with PIPE_WE=0 → WRITE_ENABLE=1 in N+2; HAZARD=0 from N+3.
- Contention:
  - MDU pushes x21=87654321 while PIPE_WE=1 for 3 cycles → x21 written in the cycle after the last pipeline write is presented.
- Full FIFO:
  - PIPE_WE held 1 with 5 back-to-back MDU results → MDU_READY=0 after the 4th push; the 5th is held at the MDU.
  - Release PIPE_WE → 4 writes in push order, then the 5th.
- Reset mid-operation:
  - RESET with 2 FIFO entries and busy bits set → no writes after release; HAZARD=0.
  - With WB_STARVE_GUARD_EN: 8 blocked cycles → PIPE_HOLD=1.
